// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the data-memory access stage: access-size
// codes, FSM encoding and small lane helpers.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // funct3[1:0] carries the size (00 byte, 01 half, 10 word) for loads and stores
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic mis;
        mis = ((sz == 2'b01) && off[0]) || ((sz == 2'b10) && (off != 2'b00));
        return mis;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Selects the addressed byte/halfword lane from a read word and sign- or
// zero-extends it; word accesses pass straight through.
module load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] dout_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {addr_i, 3'b000};

    always_comb begin
        dout_o = rdata_i;
        case (funct3_i)
            F3_B:    dout_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    dout_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   dout_o = {24'd0, shifted[7:0]};
            F3_HU:   dout_o = {16'd0, shifted[15:0]};
            default: dout_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives a req/ack data-memory transaction for loads and stores,
// stalls the pipeline while it is in flight and aborts on a watchdog timeout.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] WriteData_in,
    input  logic [4:0]  rdAddr_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        MemtoReg_mem,
    output logic        RegWrite_mem,
    output logic [31:0] MemDout_mem,
    output logic [31:0] ALUResult_mem,
    output logic [4:0]  rdAddr_mem,
    output logic        exc_misalign,
    output logic        exc_buserr
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    mem_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] load_q;
    logic        buserr_q;

    logic        access;
    logic [1:0]  off;
    logic        misal;
    logic        start;
    logic        expire;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_aligned;

    assign access = MemRead_in | MemWrite_in;
    assign off    = ALUResult_in[1:0];
    assign misal  = access & is_misaligned(funct3_in[1:0], off);
    assign start  = (state_q == IDLE) & access & ~misal;
    assign expire = (cnt_q == CW'(MAX_WAIT - 1));

    assign stall_mem    = start | (state_q == BUSY);
    assign exc_misalign = (state_q == IDLE) & misal;
    assign exc_buserr   = (state_q == DONE) & buserr_q;

    assign ALUResult_mem = ALUResult_in;
    assign rdAddr_mem    = rdAddr_in;
    assign MemtoReg_mem  = MemtoReg_in;
    assign RegWrite_mem  = RegWrite_in & ~exc_misalign & ~exc_buserr;
    assign MemDout_mem   = load_q;

    // Store lanes: narrow data is replicated so the byte enables pick the lane
    assign be_d = lane_mask(funct3_in[1:0]) << off;

    always_comb begin
        wdata_d = WriteData_in;
        case (funct3_in[1:0])
            2'b00:   wdata_d = {4{WriteData_in[7:0]}};
            2'b01:   wdata_d = {2{WriteData_in[15:0]}};
            default: wdata_d = WriteData_in;
        endcase
    end

    // Upstream is stalled during BUSY, so the *_in fields still describe this access
    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .addr_i   (off),
        .funct3_i (funct3_in),
        .dout_o   (load_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            load_q     <= '0;
            buserr_q   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    buserr_q <= 1'b0;
                    if (start) begin
                        state_q    <= BUSY;
                        cnt_q      <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite_in;
                        dmem_addr  <= {ALUResult_in[31:2], 2'b00};
                        dmem_be    <= be_d;
                        dmem_wdata <= wdata_d;
                    end
                end
                BUSY: begin
                    // An ack on the expiry cycle wins over the abort
                    if (dmem_ack) begin
                        state_q  <= DONE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        load_q   <= load_aligned;
                    end else if (expire) begin
                        state_q  <= DONE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        load_q   <= '0;
                        buserr_q <= 1'b1;
                        cnt_q    <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    buserr_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage: a small word memory answers requests
// and a byte-level reference memory predicts load results and store effects.
module tb_mem_access_stage;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
    logic [2:0]  funct3_in;
    logic [31:0] ALUResult_in, WriteData_in;
    logic [4:0]  rdAddr_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_mem, MemtoReg_mem, RegWrite_mem, exc_misalign, exc_buserr;
    logic [31:0] MemDout_mem, ALUResult_mem;
    logic [4:0]  rdAddr_mem;

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];

    always #5 clk = ~clk;

    mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .funct3_in(funct3_in),
        .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in), .rdAddr_in(rdAddr_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
        .MemDout_mem(MemDout_mem), .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem),
        .exc_misalign(exc_misalign), .exc_buserr(exc_buserr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        MemRead_in = 0; MemWrite_in = 0; RegWrite_in = 0; MemtoReg_in = 0;
        funct3_in = 0; ALUResult_in = 0; WriteData_in = 0; rdAddr_in = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    // lat = cycle of the ack counted from the presentation cycle; 0 = never.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] rda, input int lat);
        int sz, off, idx, d;
        bit mis, tout, rw;
        logic [31:0] word, v, expv, exp_wd;
        logic [3:0] exp_be;
        rw  = rd || !wr;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(addr[1:0]);
        idx = int'(addr[5:2]);
        mis = (rd || wr) && (off % sz != 0);
        MemRead_in = rd; MemWrite_in = wr; funct3_in = f3; ALUResult_in = addr;
        WriteData_in = wd; rdAddr_in = rda; RegWrite_in = rw; MemtoReg_in = rd;
        @(negedge clk);
        chk("alu_pass", ALUResult_mem, addr);
        chk("rd_pass", 32'(rdAddr_mem), 32'(rda));
        chk("m2r_pass", 32'(MemtoReg_mem), 32'(rd));
        if (!(rd || wr) || mis) begin
            chk("nostall", 32'(stall_mem), 0);
            chk("noreq", 32'(dmem_req), 0);
            chk("misalign", 32'(exc_misalign), 32'(mis));
            chk("rw_gate", 32'(RegWrite_mem), 32'(rw && !mis));
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk("noreq_after", 32'(dmem_req), 0);
            @(posedge clk); #1;
            return;
        end
        chk("start_stall", 32'(stall_mem), 1);
        chk("start_req", 32'(dmem_req), 0);
        tout   = (lat < 1) || (lat > MAX_WAIT);
        d      = tout ? MAX_WAIT : lat;
        exp_be = 4'(((1 << sz) - 1) << off);
        exp_wd = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
        for (int k = 1; k <= d; k++) begin
            @(posedge clk); #1;
            dmem_ack   = (k == lat);
            dmem_rdata = slv_mem[dmem_addr[5:2]];
            if (dmem_ack && wr)
                for (int i = 0; i < 4; i++)
                    if (dmem_be[i]) slv_mem[dmem_addr[5:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
            @(negedge clk);
            chk("busy", {30'd0, stall_mem, dmem_req}, 32'd3);
            if (k == 1) begin
                chk("addr", dmem_addr, {addr[31:2], 2'b00});
                chk("we", 32'(dmem_we), 32'(wr));
                if (wr) begin
                    chk("be", 32'(dmem_be), 32'(exp_be));
                    chk("wdata", dmem_wdata, exp_wd);
                end else if (sz == 4) begin
                    chk("be_lw", 32'(dmem_be), 32'hF);
                end
            end
        end
        @(posedge clk); #1;
        dmem_ack   = tout;   // a late ack in DONE must be ignored
        dmem_rdata = $urandom();
        word = ref_mem[idx];
        v    = word >> (8 * off);
        case (f3)
            3'b000:  expv = 32'($signed(v[7:0]));
            3'b001:  expv = 32'($signed(v[15:0]));
            3'b100:  expv = 32'(v[7:0]);
            3'b101:  expv = 32'(v[15:0]);
            default: expv = word;
        endcase
        if (tout) expv = 0;
        if (wr && !tout)
            for (int i = 0; i < sz; i++) ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
        @(negedge clk);
        chk("done_stall", 32'(stall_mem), 0);
        chk("done_req", 32'(dmem_req), 0);
        chk("buserr", 32'(exc_buserr), 32'(tout));
        chk("done_rw", 32'(RegWrite_mem), 32'(rw && !tout));
        if (rd) chk("dout", MemDout_mem, expv);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, a, w;
        int sel, lat, sz;
        bit rd, wr;
        logic [2:0] f3;
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            r = $urandom(); ref_mem[i] = r; slv_mem[i] = r;
        end
        #2;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", 32'(dmem_be), 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_dout", MemDout_mem, 0);
        chk("rst_exc", {30'd0, exc_misalign, exc_buserr}, 0);
        chk("rst_stall", 32'(stall_mem), 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        ref_mem[0] = 32'hDEADBEEF; slv_mem[0] = 32'hDEADBEEF;
        do_access(1, 0, 3'b010, 32'h100, 0, 5'd3, 3);
        ref_mem[0] = 32'h80FF0000; slv_mem[0] = 32'h80FF0000;
        do_access(1, 0, 3'b000, 32'h103, 0, 5'd4, 1);
        do_access(1, 0, 3'b100, 32'h103, 0, 5'd5, 2);
        do_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 1);
        do_access(1, 0, 3'b010, 32'h100, 0, 5'd6, 1);
        do_access(1, 0, 3'b010, 32'h101, 0, 5'd7, 1);
        do_access(1, 0, 3'b010, 32'h104, 0, 5'd8, 0);
        do_access(1, 0, 3'b001, 32'h106, 0, 5'd9, MAX_WAIT);
        do_access(0, 0, 3'b000, 32'h55, 0, 5'd10, 1);

        // Reset in the middle of a transaction
        MemRead_in = 1; funct3_in = 3'b010; ALUResult_in = 32'h108; RegWrite_in = 1;
        @(posedge clk); #1;
        chk("rst_pre_req", 32'(dmem_req), 1);
        #2 rst_n = 0;
        #1 chk("rst_mid_req", 32'(dmem_req), 0);
        idle_inputs();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        do_access(1, 0, 3'b010, 32'h10C, 0, 5'd11, 1);

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel >= 2 && sel <= 5);
            wr  = (sel >= 6);
            if (rd) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                    3: f3 = 3'b100; default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            a  = $urandom();
            if ($urandom_range(0, 1) == 1) a = a & ~(32'(sz) - 1);
            w  = $urandom();
            case ($urandom_range(0, 19))
                0: lat = 0;
                1: lat = MAX_WAIT;
                default: lat = $urandom_range(1, 5);
            endcase
            do_access(rd, wr, f3, a, w, 5'($urandom_range(0, 31)), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
